cmp_stream_monitor: RTL and testbench
=====================================

# cmp_stream_monitor

Streaming wrapper around the 4-bit magnitude comparator. It accepts operand pairs over a valid/ready handshake and produces one registered compare code per accepted pair on a downstream handshake. It also keeps saturating event counters and raises a sticky alarm after a run of consecutive greater-than results. It sits directly downstream of the operand source and feeds the compare result stream to consumers.

## Interface
- CNT_W, 8: width of each event counter
- RUN_LEN, 3: consecutive gt results that trigger alarm; legal range 1..15

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair this cycle
- a  in  4  operand A, unsigned
- b  in  4  operand B, unsigned
- out_valid  out  1  out_code holds a result
- out_ready  in  1  consumer takes the result this cycle
- out_code  out  2  2'b00 equal, 2'b01 a>b, 2'b10 a<b; 2'b11 never driven
- clr  in  1  synchronous clear of counters, run state and alarm
- gt_cnt / lt_cnt / eq_cnt  out  CNT_W  accepted-event counts, saturating
- alarm  out  1  sticky run alarm

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready, so the output stage is a single register that can be refilled in the cycle it drains.
- On accept, out_code is loaded from the combinational compare of a and b, and out_valid is set.
- out_valid clears on out_ready with no accept. out_code and out_valid hold while out_valid && !out_ready.
- On accept, exactly one of gt_cnt, lt_cnt or eq_cnt increments. Each counter saturates at 2^CNT_W-1 and never wraps.
- Run FSM:
  - IDLE (run=0): a gt accept moves to RUN with run=1, or to ALARM if RUN_LEN=1.
  - RUN: a gt accept increments run, and moves to ALARM when run reaches RUN_LEN. An eq or lt accept returns to IDLE with run=0.
  - ALARM: alarm=1. The state is held for all inputs until clr or reset.
  - No accept: the state holds.
- clr takes priority. In its cycle, the counters, run and FSM go to 0/IDLE and alarm goes to 0. A pair accepted in the same cycle still goes to out_code but is not counted and does not affect the run.
- Reset mid-transfer drops any pending result. No replay.

## Timing
- Reset values: out_valid=0, out_code=2'b00, gt_cnt=lt_cnt=eq_cnt=0, alarm=0, FSM=IDLE. in_ready=1 from the first cycle after reset release.
- Latency: a pair accepted at edge N appears with out_valid=1 after edge N; counters update at the same edge.
- alarm rises after the edge that accepts the RUN_LEN-th consecutive gt pair.
- Throughput: one pair per cycle while out_ready=1. in_ready drops combinationally with !out_ready while out_valid=1.
- The only combinational input-to-output path is out_ready -> in_ready.

## Structure
- Shared package: the out_code encodings (CMP_EQ, CMP_GT, CMP_LT) and the FSM state enum (IDLE, RUN, ALARM).
- Sub-module: comparator_4bit, instantiated unchanged. Its equal/gt/lt outputs are encoded to out_code locally.
- Run counter is 4 bits wide.

## Test plan
- Reset with in_valid=1 held -> all outputs at reset values. After release, in_ready=1 and the first pair (a=5, b=3) gives out_code=01 one cycle later with gt_cnt=1.
- Back-to-back pairs (9,9), (2,7), (15,0) with out_ready=1 -> out_code 00, 10, 01 on consecutive cycles; eq_cnt=lt_cnt=gt_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_code stable, no counter change. Release gives one accept per cycle.
- RUN_LEN=3: gt, gt, eq, gt, gt, gt -> alarm stays 0 until after the sixth accept, then alarm=1. A following lt leaves alarm=1.
- CNT_W=2: five gt accepts -> gt_cnt sequence 1, 2, 3, 3, 3.
- clr asserted together with an accept of (1,4) while alarm=1 -> next cycle counters=0, alarm=0, FSM=IDLE, out_code=10, lt_cnt=0.

Source files
------------

// File: rtl/cmp_stream_monitor_pkg.sv
// Shared definitions for the compare stream monitor: result encodings and
// the run-detection state type.
package cmp_stream_monitor_pkg;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } run_state_e;

endpackage

// File: rtl/cmp_stream_monitor_comparator_4bit.sv
// Unsigned 4-bit magnitude comparator, purely combinational.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       equal,
  output logic       gt,
  output logic       lt
);

  assign equal = (a == b);
  assign gt    = (a > b);
  assign lt    = (a < b);

endmodule

// File: rtl/cmp_stream_monitor.sv
// Handshaked wrapper around comparator_4bit: one registered compare code per
// accepted pair, saturating event counters and a sticky greater-than run alarm.
//
// state | meaning
// IDLE  | no gt run in progress, run = 0
// RUN   | run consecutive gt pairs accepted, below RUN_LEN
// ALARM | RUN_LEN consecutive gt pairs seen; held until clr or reset
module cmp_stream_monitor
  import cmp_stream_monitor_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_code,
  input  logic             clr,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             alarm
);

  localparam logic [3:0]       RUN_LEN_4 = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic       eq_w, gt_w, lt_w;
  logic       accept;
  logic [1:0] code_c;
  logic [3:0] run_q, run_n;
  run_state_e state_q, state_n;

  comparator_4bit u_cmp (
    .a     (a),
    .b     (b),
    .equal (eq_w),
    .gt    (gt_w),
    .lt    (lt_w)
  );

  always_comb begin
    code_c = CMP_LT;
    if (eq_w)      code_c = CMP_EQ;
    else if (gt_w) code_c = CMP_GT;
  end

  // Single output register that may be refilled in the cycle it drains.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= CMP_EQ;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_code  <= code_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (clr) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (accept) begin
      if (gt_w && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
      if (lt_w && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
      if (eq_w && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_n;
      run_q   <= run_n;
    end
  end

  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    if (clr) begin
      state_n = IDLE;
      run_n   = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (gt_w) begin
            run_n   = 4'd1;
            state_n = (RUN_LEN_4 == 4'd1) ? ALARM : RUN;
          end
        end
        RUN: begin
          if (gt_w) begin
            run_n = run_q + 4'd1;
            if (run_n == RUN_LEN_4) state_n = ALARM;
          end else begin
            run_n   = '0;
            state_n = IDLE;
          end
        end
        ALARM: ;
        default: begin
          state_n = IDLE;
          run_n   = '0;
        end
      endcase
    end
  end

  assign alarm = (state_q == ALARM);

endmodule

// File: tb/tb_cmp_stream_monitor.sv
// Scoreboard bench for cmp_stream_monitor: a default instance (CNT_W=8,
// RUN_LEN=3) and a narrow one (CNT_W=2, RUN_LEN=1) for saturation/boundary.
module tb_cmp_stream_monitor;

  localparam int RUN_LEN = 3;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, clr, alarm;
  logic [3:0] a, b;
  logic [1:0] out_code;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, clr2, alarm2;
  logic [3:0] a2, b2;
  logic [1:0] out_code2;
  logic [1:0] gt_cnt2, lt_cnt2, eq_cnt2;

  int total = 0;
  int bad   = 0;

  logic [1:0] sb[$];
  int m_gt, m_lt, m_eq, m_run;
  logic m_alarm;

  always #5 clk = ~clk;

  cmp_stream_monitor #(.CNT_W(8), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .clr(clr), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
    .eq_cnt(eq_cnt), .alarm(alarm)
  );

  cmp_stream_monitor #(.CNT_W(2), .RUN_LEN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_code(out_code2), .clr(clr2), .gt_cnt(gt_cnt2), .lt_cnt(lt_cnt2),
    .eq_cnt(eq_cnt2), .alarm(alarm2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_code(input logic [3:0] x, input logic [3:0] y);
    if (x > y) return 2'b01;
    if (x < y) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_gt = 0; m_lt = 0; m_eq = 0; m_run = 0; m_alarm = 1'b0;
  endtask

  task automatic check_state();
    chk("gt_cnt", gt_cnt, m_gt);
    chk("lt_cnt", lt_cnt, m_lt);
    chk("eq_cnt", eq_cnt, m_eq);
    chk("alarm", alarm, m_alarm);
  endtask

  // Called just after a rising edge; applies inputs for one cycle.
  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic ordy, input logic c);
    logic exp_ready, acc;
    in_valid = v; a = av; b = bv; out_ready = ordy; clr = c;
    #1;
    exp_ready = (sb.size() == 0) || ordy;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("out_code", out_code, sb[0]);
      if (ordy) void'(sb.pop_front());
    end
    acc = v && exp_ready;
    if (acc) sb.push_back(exp_code(av, bv));
    if (c) model_clear();
    else if (acc) begin
      if (av > bv)      m_gt = (m_gt == CNT_MAX) ? m_gt : m_gt + 1;
      else if (av < bv) m_lt = (m_lt == CNT_MAX) ? m_lt : m_lt + 1;
      else              m_eq = (m_eq == CNT_MAX) ? m_eq : m_eq + 1;
      if (!m_alarm) begin
        if (av > bv) begin
          m_run++;
          if (m_run >= RUN_LEN) m_alarm = 1'b1;
        end else m_run = 0;
      end
    end
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    int gt_seq[5];
    gt_seq = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    in_valid = 1'b1; a = 4'd5; b = 4'd3; out_ready = 1'b1; clr = 1'b0;
    in_valid2 = 1'b0; a2 = 4'd0; b2 = 4'd0; out_ready2 = 1'b1; clr2 = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_code", out_code, 2'b00);
    check_state();
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 1'b1);

    drive(1, 4'd5, 4'd3, 1, 0);
    drive(1, 4'd9, 4'd9, 1, 0);
    drive(1, 4'd2, 4'd7, 1, 0);
    drive(1, 4'd15, 4'd0, 1, 0);
    // Backpressure: result held, no accepts, counters frozen
    repeat (3) drive(1, 4'd1, 4'd1, 0, 0);
    drive(1, 4'd3, 4'd8, 1, 0);
    drive(1, 4'd8, 4'd3, 1, 0);
    drive(1, 4'd4, 4'd4, 1, 0);

    drive(0, 4'd0, 4'd0, 1, 1);
    drive(1, 4'd9, 4'd1, 1, 0);
    drive(1, 4'd9, 4'd2, 1, 0);
    drive(1, 4'd6, 4'd6, 1, 0);
    drive(1, 4'd7, 4'd1, 1, 0);
    drive(1, 4'd7, 4'd2, 1, 0);
    drive(1, 4'd7, 4'd3, 1, 0);
    drive(1, 4'd0, 4'd9, 1, 0);
    drive(0, 4'd0, 4'd0, 1, 0);

    // clr together with an accept while alarmed
    drive(1, 4'd1, 4'd4, 1, 1);
    drive(0, 4'd0, 4'd0, 1, 0);

    // Narrow instance: saturation at 3 and alarm on the first gt
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; a2 = 4'd12; b2 = 4'(i);
      #1;
      chk("d2 in_ready", in_ready2, 1'b1);
      @(posedge clk); #1;
      chk("d2 gt_cnt", gt_cnt2, gt_seq[i]);
      chk("d2 out_code", out_code2, 2'b01);
      chk("d2 out_valid", out_valid2, 1'b1);
      chk("d2 alarm", alarm2, 1'b1);
      chk("d2 lt_cnt", lt_cnt2, 2'd0);
      chk("d2 eq_cnt", eq_cnt2, 2'd0);
    end
    in_valid2 = 1'b0;

    for (int i = 0; i < 80; i++)
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);

    // Reset with a result pending: it must be dropped
    drive(1, 4'd6, 4'd2, 1, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_clear();
    chk("midrst out_valid", out_valid, 1'b0);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 4'd0, 4'd0, 1, 0);
    drive(1, 4'd3, 4'd3, 1, 0);
    drive(0, 4'd0, 4'd0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
